// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=7 rate-1/2 hard-decision Viterbi decoder:
// code constants, FSM encoding and the encoder output function.
package viterbi_pkg;

    localparam int         K          = 7;
    localparam int         NUM_STATES = 1 << (K - 1);
    localparam logic [6:0] G0         = 7'o133;
    localparam logic [6:0] G1         = 7'o171;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fsm_state_t;

    // Encoder output {A,B} for input bit u leaving trellis state s (s[5] newest).
    function automatic logic [1:0] expected_pair(input logic [5:0] state, input logic u);
        logic [6:0] taps;
        taps = {u, state};
        return {^(taps & G0), ^(taps & G1)};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// One add-compare-select unit: picks the cheaper of two predecessor paths,
// saturating the sum so a metric can never wrap, and extends the winning
// survivor with the decoded input bit of the destination state.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int METRIC_W = 8,
    parameter int TB_DEPTH = 48
) (
    input  logic [METRIC_W-1:0] metric0,
    input  logic [METRIC_W-1:0] metric1,
    input  logic [1:0]          bm0,
    input  logic [1:0]          bm1,
    input  logic [TB_DEPTH-2:0] surv0,
    input  logic [TB_DEPTH-2:0] surv1,
    input  logic                u,
    output logic [METRIC_W-1:0] metric_new,
    output logic [TB_DEPTH-1:0] surv_new,
    output logic                decision
);

    logic [METRIC_W:0] sum0;
    logic [METRIC_W:0] sum1;
    logic [METRIC_W:0] best;

    // Add, compare (ties keep predecessor 0), select metric and survivor.
    always_comb begin
        sum0       = {1'b0, metric0} + {{(METRIC_W-1){1'b0}}, bm0};
        sum1       = {1'b0, metric1} + {{(METRIC_W-1){1'b0}}, bm1};
        decision   = (sum1 < sum0);
        best       = decision ? sum1 : sum0;
        metric_new = best[METRIC_W] ? '1 : best[METRIC_W-1:0];
        surv_new   = decision ? {surv1, u} : {surv0, u};
    end

endmodule

// File: rtl/viterbi_decoder_k7.sv
// Hard-decision Viterbi decoder for the 802.11a K=7 rate-1/2 code.
// 64 parallel ACS units with register-exchange survivors of TB_DEPTH bits.
// Build option: VITERBI_ERASURE_EN adds InErase; erased bits score zero.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for first pair; metrics re-initialised on accept
// ST_RUN   | one ACS step per accepted pair, oldest bit out once full
// ST_FLUSH | input blocked; remaining bits read from the state-0 survivor
module viterbi_decoder_k7
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = 48,
    parameter int METRIC_W = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       InValid,
    output logic       InReady,
    input  logic [1:0] InBits,
`ifdef VITERBI_ERASURE_EN
    input  logic [1:0] InErase,
`endif
    input  logic       InLast,
    output logic       OutValid,
    output logic       OutBit,
    output logic       OutLast
);

    localparam int                  CNT_W       = $clog2(TB_DEPTH + 1);
    localparam int                  FPOS_W      = $clog2(TB_DEPTH);
    localparam logic [CNT_W-1:0]    CNT_FULL    = CNT_W'(TB_DEPTH);
    localparam logic [FPOS_W-1:0]   FPOS_FULL   = FPOS_W'(TB_DEPTH - 2);
    localparam logic [METRIC_W-1:0] INIT_METRIC = {2'b01, {(METRIC_W-2){1'b0}}};

    function automatic logic [1:0] branch_metric(input logic [1:0] diff);
        return {diff[1] & diff[0], diff[1] ^ diff[0]};
    endfunction

    fsm_state_t          state;
    fsm_state_t          state_nxt;
    logic                accept;
    logic                idle;
    logic [1:0]          score_mask;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic                run_pend;
    logic [FPOS_W-1:0]   flush_pos;
    logic                out_valid_nxt;
    logic                out_bit_nxt;
    logic                out_last_nxt;

    logic [METRIC_W-1:0] metric     [NUM_STATES];
    logic [TB_DEPTH-1:0] surv       [NUM_STATES];
    logic [METRIC_W-1:0] metric_acs [NUM_STATES];
    logic [METRIC_W-1:0] metric_nxt [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_acs   [NUM_STATES];
    logic [NUM_STATES-1:0] msb_vec;
    logic                normalise;
    // Register exchange carries survivors directly; per-state decisions are not consumed.
    logic [NUM_STATES-1:0] dec_unused;

    logic [METRIC_W-1:0] best_metric;
    logic [5:0]          best_idx;

    assign idle    = (state == ST_IDLE);
    assign InReady = !Reset && (state != ST_FLUSH);
    assign accept  = InValid && InReady;

`ifdef VITERBI_ERASURE_EN
    assign score_mask = ~InErase;
`else
    assign score_mask = 2'b11;
`endif

    for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
        localparam int                  P0    = (2 * n) % NUM_STATES;
        localparam int                  P1    = P0 + 1;
        localparam logic                U     = (n >= NUM_STATES / 2);
        localparam logic [1:0]          EXP0  = expected_pair(6'(P0), U);
        localparam logic [1:0]          EXP1  = expected_pair(6'(P1), U);
        localparam logic [METRIC_W-1:0] INIT0 = (P0 == 0) ? '0 : INIT_METRIC;

        logic [1:0]          bm0;
        logic [1:0]          bm1;
        logic [METRIC_W-1:0] m0;
        logic [METRIC_W-1:0] m1;
        logic [TB_DEPTH-2:0] s0;
        logic [TB_DEPTH-2:0] s1;

        assign bm0 = branch_metric((InBits ^ EXP0) & score_mask);
        assign bm1 = branch_metric((InBits ^ EXP1) & score_mask);
        assign m0  = idle ? INIT0 : metric[P0];
        assign m1  = idle ? INIT_METRIC : metric[P1];
        assign s0  = idle ? '0 : surv[P0][TB_DEPTH-2:0];
        assign s1  = idle ? '0 : surv[P1][TB_DEPTH-2:0];

        viterbi_acs #(
            .METRIC_W (METRIC_W),
            .TB_DEPTH (TB_DEPTH)
        ) u_acs (
            .metric0    (m0),
            .metric1    (m1),
            .bm0        (bm0),
            .bm1        (bm1),
            .surv0      (s0),
            .surv1      (s1),
            .u          (U),
            .metric_new (metric_acs[n]),
            .surv_new   (surv_acs[n]),
            .decision   (dec_unused[n])
        );

        assign msb_vec[n]    = metric_acs[n][METRIC_W-1];
        assign metric_nxt[n] = normalise ? {1'b0, metric_acs[n][METRIC_W-2:0]} : metric_acs[n];
    end

    assign normalise = &msb_vec;

    // Lowest-metric state over the registered metrics; ties go to the lowest index.
    always_comb begin
        best_metric = metric[0];
        best_idx    = '0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (metric[i] < best_metric) begin
                best_metric = metric[i];
                best_idx    = 6'(i);
            end
        end
    end

    // Pair count after the current accept, saturating once the survivors are full.
    always_comb begin
        if (idle)
            cnt_inc = CNT_W'(1);
        else if (cnt == CNT_FULL)
            cnt_inc = cnt;
        else
            cnt_inc = cnt + 1'b1;
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt     = state;
        out_valid_nxt = 1'b0;
        out_bit_nxt   = 1'b0;
        out_last_nxt  = 1'b0;
        case (state)
            ST_IDLE, ST_RUN: begin
                if (accept)
                    state_nxt = InLast ? ST_FLUSH : ST_RUN;
            end
            ST_FLUSH: begin
                if (!run_pend && flush_pos == '0)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (run_pend) begin
            out_valid_nxt = 1'b1;
            out_bit_nxt   = surv[best_idx][TB_DEPTH-1];
        end else if (state == ST_FLUSH) begin
            out_valid_nxt = 1'b1;
            out_bit_nxt   = surv[0][flush_pos];
            out_last_nxt  = (flush_pos == '0);
        end
    end

    // FSM state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Path metrics, survivors, counters and registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt       <= '0;
            run_pend  <= 1'b0;
            flush_pos <= '0;
            OutValid  <= 1'b0;
            OutBit    <= 1'b0;
            OutLast   <= 1'b0;
            for (int i = 0; i < NUM_STATES; i++) begin
                metric[i] <= '0;
                surv[i]   <= '0;
            end
        end else begin
            OutValid <= out_valid_nxt;
            OutBit   <= out_bit_nxt;
            OutLast  <= out_last_nxt;
            run_pend <= accept && (cnt_inc == CNT_FULL);
            if (accept) begin
                cnt <= cnt_inc;
                for (int i = 0; i < NUM_STATES; i++) begin
                    metric[i] <= metric_nxt[i];
                    surv[i]   <= surv_acs[i];
                end
            end
            if (accept && InLast)
                flush_pos <= (cnt_inc == CNT_FULL) ? FPOS_FULL : FPOS_W'(cnt_inc - 1'b1);
            else if (state == ST_FLUSH && !run_pend && flush_pos != '0)
                flush_pos <= flush_pos - 1'b1;
        end
    end

endmodule

// File: tb/tb_viterbi_decoder_k7.sv
// Self-checking bench for viterbi_decoder_k7: frames are encoded here from
// random/PRBS data with a plain shift-register encoder; with correctable input
// the decoder must return exactly the source bits, tail included.
module tb_viterbi_decoder_k7;

    localparam int TB_DEPTH = 48;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_bits;
    logic       in_last;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;
`ifdef VITERBI_ERASURE_EN
    logic [1:0] in_erase;
    logic [1:0] erase_q[$];
`endif

    always #5 clock = ~clock;

    viterbi_decoder_k7 #(.TB_DEPTH(TB_DEPTH), .METRIC_W(8)) dut (
        .Clock    (clock),
        .Reset    (reset),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .InBits   (in_bits),
`ifdef VITERBI_ERASURE_EN
        .InErase  (in_erase),
`endif
        .InLast   (in_last),
        .OutValid (out_valid),
        .OutBit   (out_bit),
        .OutLast  (out_last)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_cnt = 0;
    int         first_acc_cyc;
    int         last_acc_cyc;
    bit         data_q[$];
    logic [1:0] pair_q[$];
    bit         out_q[$];
    bit         last_q[$];
    int         ocyc_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (out_valid === 1'b1) begin
            out_q.push_back(out_bit);
            last_q.push_back(out_last);
            ocyc_q.push_back(cyc);
            if (out_last === 1'b1) last_cnt <= last_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit dbit(input int t);
        return (t < 0) ? 1'b0 : data_q[t];
    endfunction

    // n pairs total, the last 6 data bits zero; kind 0 all-zero, kind 1 PRBS-9.
    task automatic build_frame(input int n, input int kind);
        logic [8:0] lfsr;
        bit         fb;
        bit         a;
        bit         b;
        lfsr = 9'($urandom_range(511, 1));
        data_q.delete();
        pair_q.delete();
`ifdef VITERBI_ERASURE_EN
        erase_q.delete();
`endif
        for (int i = 0; i < n; i++) begin
            fb   = lfsr[8] ^ lfsr[4];
            lfsr = {lfsr[7:0], fb};
            data_q.push_back((kind == 1 && i < n - 6) ? fb : 1'b0);
        end
        for (int t = 0; t < n; t++) begin
            a = dbit(t) ^ dbit(t-2) ^ dbit(t-3) ^ dbit(t-5) ^ dbit(t-6);
            b = dbit(t) ^ dbit(t-1) ^ dbit(t-2) ^ dbit(t-3) ^ dbit(t-6);
            pair_q.push_back({a, b});
`ifdef VITERBI_ERASURE_EN
            erase_q.push_back(2'b00);
`endif
        end
    endtask

    task automatic clear_out();
        out_q.delete();
        last_q.delete();
        ocyc_q.delete();
    endtask

    // Offer pairs with random InValid gaps until stop_at pairs are accepted.
    task automatic drive(input int gap_pct, input int stop_at);
        int i = 0;
        int guard = 0;
        bit acc;
        while (i < stop_at && guard < 20000) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_bits  = pair_q[i];
            in_last  = (i == pair_q.size() - 1);
`ifdef VITERBI_ERASURE_EN
            in_erase = erase_q[i];
`endif
            @(negedge clock);
            acc = in_valid && in_ready;
            if (acc) begin
                if (i == 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
            end
            @(posedge clock);
            #1;
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("drive_accepts", i, stop_at);
    endtask

    // Wait for OutLast, poking junk at the input only while it is not ready.
    task automatic wait_last(input int budget);
        int start = last_cnt;
        for (int k = 0; k < budget && last_cnt == start; k++) begin
            in_valid = !in_ready && ($urandom_range(1) == 1);
            in_bits  = 2'($urandom);
            in_last  = 1'($urandom);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("frame_end", last_cnt - start, 1);
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic check_frame(input string name, input int n);
        int m;
        chk($sformatf("%s count", name), out_q.size(), n);
        m = (out_q.size() < n) ? out_q.size() : n;
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s bit%0d", name, i), out_q[i], data_q[i]);
            chk($sformatf("%s last%0d", name, i), last_q[i], (i == n - 1));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clock);
        chk({name, " InReady"}, in_ready, 0);
        chk({name, " OutValid"}, out_valid, 0);
        chk({name, " OutBit"}, out_bit, 0);
        chk({name, " OutLast"}, out_last, 0);
    endtask

    task automatic run_frame(input string name, input int n, input int kind, input int gap);
        build_frame(n, kind);
        clear_out();
        drive(gap, n);
        wait_last(4 * n + 200);
        check_frame(name, n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] tmp;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_bits  = 2'b00;
        in_last  = 1'b0;
`ifdef VITERBI_ERASURE_EN
        in_erase = 2'b00;
`endif
        repeat (2) @(posedge clock);
        check_reset_outputs("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;

        // All-zero frame, continuous input: latency and OutLast position.
        run_frame("zero", 100, 0, 0);
        chk("latency", (ocyc_q.size() > 0) ? ocyc_q[0] - first_acc_cyc : -1, TB_DEPTH + 1);

        // Error-free PRBS frame with random gaps.
        run_frame("prbs", 200, 1, 30);

        // Single-bit channel errors at pairs 30, 90, 150.
        build_frame(200, 1);
        foreach (pair_q[i]) begin
            if (i == 30 || i == 90 || i == 150)
                pair_q[i] = pair_q[i] ^ (($urandom_range(1) == 1) ? 2'b10 : 2'b01);
        end
        clear_out();
        drive(20, 200);
        wait_last(1000);
        check_frame("errs", 200);

        // Short frame: everything comes out after the last accept.
        run_frame("short", 10, 1, 0);
        chk("short no_run", (ocyc_q.size() > 0) && (ocyc_q[0] > last_acc_cyc), 1);

        // Boundary lengths.
        run_frame("n1", 1, 0, 0);
        run_frame("n_depth", TB_DEPTH, 1, 25);
        run_frame("n_depth1", TB_DEPTH + 1, 1, 0);

        // Reset mid-frame, then a fresh frame straight away.
        build_frame(200, 1);
        clear_out();
        drive(10, 60);
        reset = 1'b1;
        check_reset_outputs("midreset");
        @(posedge clock);
        #1;
        clear_out();
        reset = 1'b0;
        #1;
        run_frame("after_reset", 120, 1, 15);

`ifdef VITERBI_ERASURE_EN
        // Rate-3/4 puncturing: B dropped on every 2nd pair, A on every 3rd of each triplet.
        build_frame(200, 1);
        foreach (pair_q[i]) begin
            tmp = pair_q[i];
            if (i % 3 == 1) begin
                erase_q[i] = 2'b01;
                tmp[0]     = 1'($urandom);
            end else if (i % 3 == 2) begin
                erase_q[i] = 2'b10;
                tmp[1]     = 1'($urandom);
            end
            pair_q[i] = tmp;
        end
        clear_out();
        drive(20, 200);
        wait_last(1000);
        check_frame("punct34", 200);

        // Fully erased all-ones input must decode as zeros.
        build_frame(60, 0);
        foreach (pair_q[i]) begin
            pair_q[i]  = 2'b11;
            erase_q[i] = 2'b11;
        end
        clear_out();
        drive(0, 60);
        wait_last(400);
        check_frame("erased", 60);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
